// File: rtl/conv_ctrl_if.sv
// Bundle of control, geometry and result-tag signals between the layer top and conv_ctrl.
// master: the sequencer (conv_ctrl). slave: the layer-level top / datapath consumer.
interface conv_ctrl_if;
  logic       start;
  logic       mode;
  logic [4:0] matrix_in;
  logic [9:0] matrix2_in;
  logic       out_ready;
  logic [9:0] i;
  logic [1:0] prov;
  logic [4:0] matrix;
  logic [9:0] matrix2;
  logic       conv_en;
  logic       dense_en;
  logic [3:0] filt;
  logic       y_valid;
  logic [9:0] y_idx;
  logic [3:0] y_filt;
  logic       busy;
  logic       done;

  modport master (
    input  start, mode, matrix_in, matrix2_in, out_ready,
    output i, prov, matrix, matrix2, conv_en, dense_en, filt,
    output y_valid, y_idx, y_filt, busy, done
  );

  modport slave (
    output start, mode, matrix_in, matrix2_in, out_ready,
    input  i, prov, matrix, matrix2, conv_en, dense_en, filt,
    input  y_valid, y_idx, y_filt, busy, done
  );
endinterface

// File: rtl/conv_ctrl.sv
// Sequencer for the conv 3x3 MAC datapath: sweeps pixel index i once per filter, generates the
// left/right boundary code and enables, and tags each datapath result with its pixel and filter.
// Optional feature macro: CONV_CTRL_STALL_EN (out_ready gates issue; otherwise issue every cycle).
module conv_ctrl #(
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned LATENCY     = 1
) (
  input logic        clk,
  input logic        rst,
  conv_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  typedef struct packed {
    logic       vld;
    logic [3:0] filt;
    logic [9:0] idx;
  } tag_t;

  localparam logic [3:0] LastFilt = 4'(NUM_FILTERS - 1);

  state_e     state_q, state_d;
  logic [9:0] i_q, i_d;
  logic [4:0] col_q, col_d;
  logic [3:0] filt_q, filt_d;
  logic       mode_q, mode_d;
  logic [4:0] matrix_q, matrix_d;
  logic [9:0] matrix2_q, matrix2_d;

  tag_t [LATENCY-1:0] pipe_q, pipe_d;
  logic [LATENCY-1:0] pipe_vld_d;
  tag_t               new_tag;
  logic               issue;
  logic               last_pix;
  logic               active;

`ifdef CONV_CTRL_STALL_EN
  assign issue = (state_q == StRun) && bus.out_ready;
`else
  logic unused_out_ready;
  assign unused_out_ready = bus.out_ready;
  assign issue = (state_q == StRun);
`endif

  assign last_pix = (i_q == matrix2_q - 10'd1);
  assign new_tag  = '{vld: issue, filt: filt_q, idx: i_q};

  // Tag pipeline shifts every cycle, mirroring the datapath's fixed latency.
  if (LATENCY == 1) begin : g_lat1
    assign pipe_d = new_tag;
  end else begin : g_latn
    assign pipe_d = {pipe_q[LATENCY-2:0], new_tag};
  end

  for (genvar k = 0; k < LATENCY; k++) begin : g_vld
    assign pipe_vld_d[k] = pipe_d[k].vld;
  end

  // Next-state logic for the sweep FSM and its counters.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    col_d     = col_q;
    filt_d    = filt_q;
    mode_d    = mode_q;
    matrix_d  = matrix_q;
    matrix2_d = matrix2_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d    = bus.mode;
          matrix_d  = bus.matrix_in;
          matrix2_d = bus.matrix2_in;
          i_d       = '0;
          col_d     = '0;
          filt_d    = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (issue) begin
          if (last_pix) begin
            i_d    = '0;
            col_d  = '0;
            filt_d = filt_q + 4'd1;
            if (filt_q == LastFilt) state_d = StDrain;
          end else begin
            i_d   = i_q + 10'd1;
            col_d = (col_q == matrix_q - 5'd1) ? 5'd0 : col_q + 5'd1;
          end
        end
      end
      // Leave once the last in-flight tag is on the output this cycle.
      StDrain: if (pipe_vld_d == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, counters, latched geometry and tag pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      i_q       <= '0;
      col_q     <= '0;
      filt_q    <= '0;
      mode_q    <= 1'b0;
      matrix_q  <= '0;
      matrix2_q <= '0;
      pipe_q    <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      col_q     <= col_d;
      filt_q    <= filt_d;
      mode_q    <= mode_d;
      matrix_q  <= matrix_d;
      matrix2_q <= matrix2_d;
      pipe_q    <= pipe_d;
    end
  end

  // Outputs decoded from registered state; prov only flags left/right edges in conv mode.
  always_comb begin
    active       = (state_q == StRun) || (state_q == StDrain);
    bus.conv_en  = active;
    bus.dense_en = active & mode_q;
    bus.busy     = active;
    bus.done     = (state_q == StDone);
    bus.prov     = 2'b00;
    if (active && !mode_q) begin
      if (col_q == 5'd0)                  bus.prov = 2'b10;
      else if (col_q == matrix_q - 5'd1)  bus.prov = 2'b11;
    end
    bus.i       = i_q;
    bus.filt    = filt_q;
    bus.matrix  = matrix_q;
    bus.matrix2 = matrix2_q;
    bus.y_valid = pipe_q[LATENCY-1].vld;
    bus.y_idx   = pipe_q[LATENCY-1].idx;
    bus.y_filt  = pipe_q[LATENCY-1].filt;
  end

endmodule

// File: tb/tb_conv_ctrl.sv
// Directed bench for conv_ctrl with a tag scoreboard and a cycle model of the sweep.
module tb_conv_ctrl;

  localparam int unsigned NF  = 4;
  localparam int unsigned LAT = 2;
`ifdef CONV_CTRL_STALL_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  conv_ctrl_if bus ();

  conv_ctrl #(.NUM_FILTERS(NF), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_done   = 0;
  logic [13:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every tagged result must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.y_valid) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        failures++;
        $error("FAIL y_extra observed=%0h expected=none", {bus.y_filt, bus.y_idx});
      end
      if (sb_q.size() != 0) check("y_tag", {bus.y_filt, bus.y_idx}, sb_q.pop_front());
    end
    if (!rst && bus.done) n_done++;
  end

  task automatic check_reset(input string pfx);
    check({pfx, "_i"}, bus.i, 0);
    check({pfx, "_prov"}, bus.prov, 0);
    check({pfx, "_matrix"}, bus.matrix, 0);
    check({pfx, "_matrix2"}, bus.matrix2, 0);
    check({pfx, "_conv_en"}, bus.conv_en, 0);
    check({pfx, "_dense_en"}, bus.dense_en, 0);
    check({pfx, "_filt"}, bus.filt, 0);
    check({pfx, "_y_valid"}, bus.y_valid, 0);
    check({pfx, "_y_idx"}, bus.y_idx, 0);
    check({pfx, "_y_filt"}, bus.y_filt, 0);
    check({pfx, "_busy"}, bus.busy, 0);
    check({pfx, "_done"}, bus.done, 0);
  endtask

  // One full run: per-cycle compare against a model, stall window, optional ignored start.
  task automatic run_check(input bit md, input int m, input int m2, input int stall_at,
                           input int stall_len, input int ign_at);
    int ei, ef, ecol, issued, cyc, stall_left;
    bit stall_done;
    logic [1:0] eprov;
    for (int f = 0; f < int'(NF); f++)
      for (int p = 0; p < m2; p++) sb_q.push_back({f[3:0], p[9:0]});
    @(posedge clk); #1;
    start = 1'b1; bus.mode = md; bus.matrix_in = 5'(m); bus.matrix2_in = 10'(m2);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ei = 0; ef = 0; ecol = 0; issued = 0; cyc = 1; stall_left = 0; stall_done = 0;
    while (issued < int'(NF) * m2 && cyc < 20000) begin
      if (stall_at >= 0 && ei == stall_at && ef == 0 && !stall_done) begin
        stall_left = stall_len;
        stall_done = 1'b1;
      end
      bus.out_ready = (stall_left == 0);
      if (cyc == ign_at) begin
        start = 1'b1; bus.matrix_in = 5'd5; bus.matrix2_in = 10'd25; bus.mode = ~md;
      end
      @(negedge clk);
      eprov = md ? 2'b00 : (ecol == 0) ? 2'b10 : (ecol == m - 1) ? 2'b11 : 2'b00;
      check("run_state",
            {bus.busy, bus.conv_en, bus.dense_en, bus.done, bus.i, bus.filt, bus.prov,
             bus.matrix, bus.matrix2},
            {1'b1, 1'b1, md, 1'b0, 10'(ei), 4'(ef), eprov, 5'(m), 10'(m2)});
      if (!StallEn || bus.out_ready) begin
        issued++;
        if (ei == m2 - 1) begin
          ei = 0; ecol = 0; ef++;
        end else begin
          ei++;
          ecol = (ecol == m - 1) ? 0 : ecol + 1;
        end
      end
      if (stall_left > 0) stall_left--;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check("run_bounded", issued, int'(NF) * m2);
    bus.out_ready = 1'b1;
    for (int k = 0; k < int'(LAT); k++) begin
      @(negedge clk);
      check("drain", {bus.busy, bus.conv_en, bus.done}, 3'b110);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("done_cycle", {bus.busy, bus.conv_en, bus.dense_en, bus.done}, 4'b0001);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_after", {bus.busy, bus.conv_en, bus.done}, 3'b000);
    check("sb_drained", sb_q.size(), 0);
  endtask

  logic start;
  assign bus.start = start;

  int done_before;

  initial begin
    start = 1'b0; bus.mode = 1'b0; bus.matrix_in = '0; bus.matrix2_in = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 28x28 conv sweep over all filters, with a start pulse mid-run that must be ignored.
    run_check(1'b0, 28, 784, -1, 0, 100);
    check("done_count_a", n_done, 1);

    // Dense mode, 100 elements.
    run_check(1'b1, 10, 100, -1, 0, -1);
    check("done_count_b", n_done, 2);

    // Abort mid-run at i=137; only tags that surfaced before the reset are expected.
    for (int p = 0; p <= 136 - int'(LAT); p++) sb_q.push_back({4'd0, 10'(p)});
    @(posedge clk); #1;
    start = 1'b1; bus.mode = 1'b0; bus.matrix_in = 5'd28; bus.matrix2_in = 10'd784;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (137) begin
      @(posedge clk); #1;
    end
    check("abort_i", bus.i, 137);
    done_before = n_done;
    rst = 1'b1;
    #1;
    check_reset("abort");
    check("abort_sb_empty", sb_q.size(), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Smallest legal image after abort; restarts from i=0.
    run_check(1'b0, 3, 9, -1, 0, -1);
    check("done_count_c", n_done, done_before + 1);

    // Backpressure window at i=40 (only stalls when the feature is built in).
    run_check(1'b0, 28, 784, 40, 5, -1);
    check("done_count_d", n_done, done_before + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
